// File: rtl/mm_pkg.sv
// Shared types, defaults and result reduction for the serial 2x2 matrix-multiply sequencer.
// Build option: define MM_SATURATE_EN to clamp results instead of wrapping them.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    SEND,
    FIN
  } mm_state_t;

  localparam int MM_DW = 4;
  localparam int MM_RW = 8;

  // Result entry indices, also the order in which results leave on serial_out.
  localparam logic [1:0] C00 = 2'd0;
  localparam logic [1:0] C01 = 2'd1;
  localparam logic [1:0] C10 = 2'd2;
  localparam logic [1:0] C11 = 2'd3;

  // Reduces a dot-product sum to rw bits; rw must stay below 32.
  function automatic logic [31:0] reduce(input logic [31:0] v, input int rw);
    logic [31:0] mask;
    mask = (32'd1 << rw) - 32'd1;
`ifdef MM_SATURATE_EN
    if ((v & ~mask) != 32'd0) return mask;
`endif
    return v & mask;
  endfunction

endpackage

// File: rtl/mm_serial_sequencer_mac.sv
// Shared multiply-accumulate unit: one product per cycle, summed onto the held partial.
module mm_mac
  import mm_pkg::*;
#(
  parameter int DW = MM_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            clr,
  input  logic            en,
  output logic [2*DW:0]   acc
);

  logic [2*DW:0] acc_q;
  logic [2*DW:0] prod;

  // acc is the value being accumulated this cycle, so the caller can store
  // a finished dot product in the same cycle as its second term.
  always_comb begin
    prod = {{(DW+1){1'b0}}, a} * {{(DW+1){1'b0}}, b};
    acc  = clr ? prod : acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/mm_serial_sequencer.sv
// Serial 2x2 matrix-multiply sequencer: loads A and B bit-serially, runs one MAC over
// the eight partial products, then streams C00..C11 out MSB first.
module mm_serial_sequencer
  import mm_pkg::*;
#(
  parameter int DW = MM_DW,
  parameter int RW = MM_RW
) (
  input  logic clk,
  input  logic RST,
  input  logic start,
  input  logic serial_in,
  output logic serial_out,
  output logic out_valid,
  output logic done,
  output logic busy
);

  localparam int OPW     = 4 * DW;
  localparam int SW      = 4 * RW;
  localparam int CNT_TOP = (OPW > SW) ? ((OPW > 8) ? OPW : 8) : ((SW > 8) ? SW : 8);
  localparam int CW      = $clog2(CNT_TOP);

  localparam logic [CW-1:0] LOAD_LAST = CW'(OPW - 1);
  localparam logic [CW-1:0] CMP_LAST  = CW'(7);
  localparam logic [CW-1:0] SEND_LAST = CW'(SW - 1);

  mm_state_t      state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic           shift_a, shift_b, mac_en, mac_clr, store_c;

  logic [OPW-1:0] a_sr, b_sr;
  logic [RW-1:0]  c_reg [4];
  logic [DW-1:0]  a_el [4];
  logic [DW-1:0]  b_el [4];
  logic [DW-1:0]  mac_a, mac_b;
  logic [2*DW:0]  mac_acc;
  logic [1:0]     entry;
  logic [SW-1:0]  c_flat, c_shifted;

  // Protocol: start is a level sampled only in IDLE; there is no back-pressure,
  // out_valid marks each result bit on serial_out and done follows the last one.
  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_a    = 1'b0;
    shift_b    = 1'b0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    store_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD_A;
          cnt_next   = CW'(1);
          shift_a    = 1'b1;
        end
      end
      LOAD_A: begin
        shift_a = 1'b1;
        if (cnt == LOAD_LAST) begin
          state_next = LOAD_B;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      LOAD_B: begin
        shift_b = 1'b1;
        if (cnt == LOAD_LAST) begin
          state_next = COMPUTE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      COMPUTE: begin
        mac_en  = 1'b1;
        mac_clr = ~cnt[0];
        store_c = cnt[0];
        if (cnt == CMP_LAST) begin
          state_next = SEND;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SEND: begin
        if (cnt == SEND_LAST) begin
          state_next = FIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The first streamed element lands in the top DW bits of each shift register.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      a_el[m] = a_sr[(3-m)*DW +: DW];
      b_el[m] = b_sr[(3-m)*DW +: DW];
    end
  end

  // Step n: entry e = n>>1, k = n&1, product A[e>>1][k] * B[k][e&1].
  always_comb begin
    entry = cnt[2:1];
    mac_a = a_el[{entry[1], cnt[0]}];
    mac_b = b_el[{cnt[0], entry[0]}];
  end

  mm_mac #(.DW(DW)) u_mac (
    .clk (clk),
    .rst (RST),
    .a   (mac_a),
    .b   (mac_b),
    .clr (mac_clr),
    .en  (mac_en),
    .acc (mac_acc)
  );

  // Output bits are chosen from the next count so they appear in the cycle they belong to.
  always_comb begin
    c_flat    = {c_reg[C00], c_reg[C01], c_reg[C10], c_reg[C11]};
    c_shifted = c_flat << cnt_next;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      for (int i = 0; i < 4; i++) c_reg[i] <= '0;
      serial_out <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (shift_a) a_sr <= {a_sr[OPW-2:0], serial_in};
      if (shift_b) b_sr <= {b_sr[OPW-2:0], serial_in};
      if (store_c) c_reg[entry] <= RW'(reduce(32'(mac_acc), RW));
      out_valid  <= (state_next == SEND);
      serial_out <= (state_next == SEND) & c_shifted[SW-1];
    end
  end

endmodule

// File: tb/tb_mm_serial_sequencer.sv
// Directed bench for mm_serial_sequencer: hand-computed products, timing and reset cases.
module tb_mm_serial_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic serial_in = 1'b0;
  logic serial_out, out_valid, done, busy;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  mm_serial_sequencer dut (
    .clk        (clk),
    .RST        (rst),
    .start      (start),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .out_valid  (out_valid),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one transaction from cycle 0 through cycle 72, sampling outputs each cycle.
  task automatic do_txn(input logic [15:0] av, input logic [15:0] bv,
                        input bit hold, input bit poke,
                        output logic [31:0] res, output int vcount,
                        output int first_v, output int last_v,
                        output int done_cyc, output int done_n,
                        output int err, output int done_abs);
    res = '0; vcount = 0; first_v = -1; last_v = -1;
    done_cyc = -1; done_n = 0; err = 0; done_abs = -1;
    @(negedge clk);
    start = 1'b1;
    serial_in = av[15];
    if (busy !== 1'b0) err++;
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      serial_in = (c < 16) ? av[15-c] : bv[31-c];
      if (busy !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) err++;
    end
    for (int c = 32; c <= 72; c++) begin
      @(negedge clk);
      if (!hold) start = poke && (c == 35 || c == 50);
      serial_in = 1'($urandom_range(0, 1));
      if (busy !== 1'b1) err++;
      if (out_valid === 1'b1) begin
        res = {res[30:0], serial_out};
        vcount++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end else if (serial_out !== 1'b0) begin
        err++;
      end
      if (done === 1'b1) begin
        done_n++;
        done_cyc = c;
        done_abs = cyc;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    logic [31:0] r1, r2, ovf_exp;
    int vc, fv, lv, dc, dn, er, da1, da2, dc2, dn2, er2, stray;

`ifdef MM_SATURATE_EN
    ovf_exp = 32'hFFFF_FFFF;
`else
    ovf_exp = 32'hC2C2_C2C2;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sout", serial_out, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // A={1,2,3,4}, B={5,6,7,8} -> 19,22,43,50
    do_txn(16'h1234, 16'h5678, 1'b0, 1'b0, r1, vc, fv, lv, dc, dn, er, da1);
    check("nom_res", r1, 32'h1316_2B32);
    check("nom_vcount", vc, 32);
    check("nom_first_valid", fv, 40);
    check("nom_last_valid", lv, 71);
    check("nom_done_cyc", dc, 72);
    check("nom_done_n", dn, 1);
    check("nom_proto", er, 0);
    @(negedge clk);
    check("nom_after_busy", busy, 0);
    check("nom_after_done", done, 0);

    // 15*15+15*15 = 450: wraps to 194 or clamps to 255
    do_txn(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, r1, vc, fv, lv, dc, dn, er, da1);
    check("ovf_res", r1, ovf_exp);
    check("ovf_done_cyc", dc, 72);

    // Identity times B returns B
    do_txn(16'h1001, 16'h7325, 1'b0, 1'b0, r1, vc, fv, lv, dc, dn, er, da1);
    check("id_res", r1, 32'h0703_0205);
    check("id_proto", er, 0);

    // Start pulses during COMPUTE and SEND are ignored
    do_txn(16'h1234, 16'h5678, 1'b0, 1'b1, r1, vc, fv, lv, dc, dn, er, da1);
    check("poke_res", r1, 32'h1316_2B32);
    check("poke_vcount", vc, 32);
    check("poke_first_valid", fv, 40);
    check("poke_done_n", dn, 1);
    check("poke_done_cyc", dc, 72);
    check("poke_proto", er, 0);

    // Reset at cycle 10 of the load aborts the transaction
    @(negedge clk);
    start = 1'b1;
    serial_in = 1'b1;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      serial_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rml_busy", busy, 0);
    check("rml_valid", out_valid, 0);
    rst = 1'b0;
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
    end
    check("rml_stray", stray, 0);
    do_txn(16'h1234, 16'h5678, 1'b0, 1'b0, r1, vc, fv, lv, dc, dn, er, da1);
    check("rml_res", r1, 32'h1316_2B32);
    check("rml_done_cyc", dc, 72);

    // Back-to-back with start held high; second set gives all zeros
    do_txn(16'h1234, 16'h5678, 1'b1, 1'b0, r1, vc, fv, lv, dc, dn, er, da1);
    do_txn(16'h0000, 16'h9999, 1'b1, 1'b0, r2, vc, fv, lv, dc2, dn2, er2, da2);
    start = 1'b0;
    check("b2b_res1", r1, 32'h1316_2B32);
    check("b2b_res2", r2, 32'h0000_0000);
    check("b2b_done1", dc, 72);
    check("b2b_done2", dc2, 72);
    check("b2b_gap", da2 - da1, 73);
    check("b2b_vcount2", vc, 32);
    check("b2b_proto", er + er2, 0);
    @(negedge clk);
    check("b2b_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_serial_sequencer.md
Name: mm_serial_sequencer

Overview:
Controller for the 2x2 serial matrix-multiply datapath. It performs four steps:
- Deserializes matrices A and B from a 1-bit input stream.
- Schedules a single shared multiply-accumulate unit over the 8 partial products.
- Stores the four results.
- Serializes C00, C01, C10, C11 back out with a valid strobe and a done pulse.

It sits between the serial pins and the arithmetic. It replaces the fully parallel multiplier array with a time-multiplexed MAC.

Parameters:
DW, 4, element width of A and B entries (unsigned)
RW, 8, result element width; results are reduced to RW bits (wrap, or saturate when the feature is enabled)

Ports:
clk  in  1  clock; all logic on posedge
RST  in  1  reset; synchronous, active-high
start  in  1  begin a transaction; sampled only in IDLE
serial_in  in  1  operand stream, MSB first: A00,A01,A10,A11 then B00,B01,B10,B11
serial_out  out  1  result stream, MSB first: C00,C01,C10,C11
out_valid  out  1  high on every cycle serial_out carries a result bit
done  out  1  one-cycle pulse after the last result bit
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST=1 at posedge, at any time including mid-transaction):
  - State goes to IDLE.
  - serial_out, out_valid, done and busy are all 0.
  - Bit counters, A/B/C registers and the accumulator are cleared.
- States: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> SEND -> FIN -> IDLE.
- IDLE:
  - If start=1 at posedge, serial_in on that same edge is captured as A bit 4*DW-1 (cycle 0). Next state is LOAD_A with bit_cnt=1.
  - start=0: remain in IDLE.
- LOAD_A: shift serial_in into A each cycle until 4*DW bits are held (cycles 0..15 at default), then go to LOAD_B.
- LOAD_B: 4*DW bits (cycles 16..31), then go to COMPUTE.
- COMPUTE: 8 cycles (32..39), step n=0..7.
  - Entry e = n>>1 in order C00, C01, C10, C11; k = n&1.
  - Product p = A[i][k]*B[k][j], where i=e>>1 and j=e&1; p is 2*DW bits.
  - k=0: acc <= p.
  - k=1: C[e] <= reduce(acc+p); acc is computed at 2*DW+1 bits before reduction.
- SEND: 4*RW cycles (40..71).
  - serial_out and out_valid are registered and driven in the cycle the bit belongs to.
  - Order: C00 MSB .. C00 LSB, then C01, C10, C11.
- FIN: done=1 for exactly one cycle (cycle 72), then IDLE. A new start is accepted from cycle 73.
- busy=1 from cycle 1 through cycle 72 inclusive.
- start is ignored outside IDLE. Holding start high through FIN launches a new transaction on the first IDLE cycle.
- Default reduce: wrap modulo 2^RW.
- Outside SEND, serial_out=0 and out_valid=0.
- Total latency at defaults: 73 cycles from start edge to done.

Optional Feature:
- Macro: MM_SATURATE_EN.
- Defined: reduce() clamps to 2^RW-1 when acc+p >= 2^RW.
- Undefined: reduce() truncates to the low RW bits (wrap).
- Cycle timing is identical either way.

Decomposition:
- Package mm_pkg holds:
  - state enum mm_state_t (IDLE, LOAD_A, LOAD_B, COMPUTE, SEND, FIN)
  - default DW/RW localparams
  - entry-index constants C00..C11
  - function reduce()
- Sub-module mm_mac holds the shared MAC.
  - Inputs: a, b (DW), clr, en.
  - Output: acc (2*DW+1 bits).
  - The sequencer instantiates exactly one mm_mac and owns all counters, the FSM and the shift registers.

Test Plan:
- Nominal: A={1,2,3,4}, B={5,6,7,8} -> serial_out decodes C00=19, C01=22, C10=43, C11=50; out_valid high for exactly 32 cycles (40..71); done pulse at cycle 72.
- Overflow: A=B={15,15,15,15} -> each C = 450. Without MM_SATURATE_EN each C=194; with MM_SATURATE_EN each C=255.
- Reset mid-load: assert RST at cycle 10 of LOAD_A -> busy=0 on the next cycle, no out_valid afterwards. A fresh nominal transaction then yields 19/22/43/50.
- Start while busy: pulse start during COMPUTE and again during SEND -> no effect; results and timing unchanged, single done pulse.
- Back-to-back: start held high continuously with two operand sets (nominal, then A={0,0,0,0}, B={9,9,9,9}) -> second transaction begins at cycle 73 and returns C=0,0,0,0; done pulses at cycles 72 and 145.
- Identity: A={1,0,0,1}, B={7,3,2,5} -> C00=7, C01=3, C10=2, C11=5.
